// File: rtl/wheel_period_meter.sv
// Wheel revolution period meter: times the spacing between accepted sensor ticks,
// rejects ticks that arrive too early and flags the wheel as stopped after a timeout.
module wheel_period_meter #(
  parameter int CNT_W      = 32,
  parameter int MIN_PERIOD = 2_500_000,
  parameter int TIMEOUT    = 100_000_000,
  parameter int REV_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             stopped,
  output logic             reject,
  output logic [REV_W-1:0] rev_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1
  } state_t;

  localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] TMO_CNT = CNT_W'(TIMEOUT);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] elapsed_q, elapsed_d;
  logic [CNT_W-1:0] period_d;
  logic             period_valid_d;
  logic             stopped_d;
  logic             reject_d;
  logic [REV_W-1:0] rev_count_d;

  // Valid/ready: none. tick is a fire-and-forget pulse sampled every cycle;
  // period_valid and reject are one-cycle strobes with no back-pressure.
  always_comb begin
    state_d        = state_q;
    elapsed_d      = elapsed_q;
    period_d       = period;
    period_valid_d = 1'b0;
    stopped_d      = stopped;
    reject_d       = 1'b0;
    rev_count_d    = rev_count;
    case (state_q)
      IDLE: begin
        elapsed_d = '0;
        if (tick) begin
          state_d     = MEASURE;
          elapsed_d   = CNT_W'(1);
          rev_count_d = rev_count + REV_W'(1);
        end
      end
      MEASURE: begin
        if (tick && (elapsed_q < MIN_CNT)) begin
          reject_d  = 1'b1;
          elapsed_d = elapsed_q + CNT_W'(1);
        end else if (tick) begin
          // A tick at exactly TIMEOUT lands here and wins over the timeout.
          period_d       = elapsed_q;
          period_valid_d = 1'b1;
          stopped_d      = 1'b0;
          rev_count_d    = rev_count + REV_W'(1);
          elapsed_d      = CNT_W'(1);
        end else if (elapsed_q == TMO_CNT) begin
          state_d   = IDLE;
          elapsed_d = '0;
          stopped_d = 1'b1;
          period_d  = '0;
        end else begin
          elapsed_d = elapsed_q + CNT_W'(1);
        end
      end
      default: begin
        state_d     = IDLE;
        elapsed_d   = '0;
        period_d    = '0;
        stopped_d   = 1'b1;
        rev_count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      elapsed_q    <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      stopped      <= 1'b1;
      reject       <= 1'b0;
      rev_count    <= '0;
    end else begin
      state_q      <= state_d;
      elapsed_q    <= elapsed_d;
      period       <= period_d;
      period_valid <= period_valid_d;
      stopped      <= stopped_d;
      reject       <= reject_d;
      rev_count    <= rev_count_d;
    end
  end

endmodule

// File: tb/tb_wheel_period_meter.sv
// Bench for wheel_period_meter: directed scenarios plus random tick trains,
// checked against a tick-timestamp model and a pulse scoreboard.
module tb_wheel_period_meter;
  localparam int CNT_W = 16;
  localparam int MIN_P = 5;
  localparam int TMO   = 50;
  localparam int REV_W = 4;
  localparam int W     = CNT_W + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             tick;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             stopped;
  logic             reject;
  logic [REV_W-1:0] rev_count;

  always #5 clk = ~clk;

  wheel_period_meter #(
    .CNT_W(CNT_W), .MIN_PERIOD(MIN_P), .TIMEOUT(TMO), .REV_W(REV_W)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .period(period),
    .period_valid(period_valid), .stopped(stopped), .reject(reject),
    .rev_count(rev_count)
  );

  // Scoreboard entries: {is_reject, period}; a reject carries period 0.
  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  // Reference model: timestamp of the last accepted tick.
  int               cyc = 0;
  bit               have_ref = 1'b0;
  int               ref_c = 0;
  logic [CNT_W-1:0] m_period = '0;
  bit               m_stopped = 1'b1;
  logic [REV_W-1:0] m_rev = '0;

  bit sched  [0:255];
  bit rsched [0:255];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d cyc=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic step(input bit t, input bit r);
    @(negedge clk);
    chk("period", 32'(period), 32'(m_period));
    chk("stopped", 32'(stopped), 32'(m_stopped));
    chk("rev_count", 32'(rev_count), 32'(m_rev));
    tick = t;
    rst  = r;
    if (r) begin
      have_ref  = 1'b0;
      m_period  = '0;
      m_stopped = 1'b1;
      m_rev     = '0;
    end else if (t) begin
      if (!have_ref) begin
        have_ref = 1'b1;
        ref_c    = cyc;
        m_rev    = m_rev + 1'b1;
      end else if (cyc - ref_c < MIN_P) begin
        exp_q.push_back({1'b1, {CNT_W{1'b0}}});
      end else begin
        m_period  = CNT_W'(cyc - ref_c);
        exp_q.push_back({1'b0, m_period});
        m_stopped = 1'b0;
        m_rev     = m_rev + 1'b1;
        ref_c     = cyc;
      end
    end else if (have_ref && (cyc - ref_c == TMO)) begin
      have_ref  = 1'b0;
      m_stopped = 1'b1;
      m_period  = '0;
    end
    cyc++;
  endtask

  task automatic clr();
    for (int i = 0; i < 256; i++) begin
      sched[i]  = 1'b0;
      rsched[i] = 1'b0;
    end
  endtask

  // One reset cycle, then len cycles following the schedules (offset 0 = first cycle after reset).
  task automatic play(input int len);
    step(1'b0, 1'b1);
    for (int i = 0; i < len; i++) step(sched[i], rsched[i]);
  endtask

  always @(negedge clk) begin
    if (period_valid || reject) begin
      logic [W-1:0] e;
      logic [W-1:0] got;
      chk("pv_and_reject_exclusive", 32'(period_valid & reject), 32'd0);
      got = {reject, reject ? {CNT_W{1'b0}} : period};
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", 32'(got), 32'h1ffff);
      end else begin
        e = exp_q.pop_front();
        chk("pulse", 32'(got), 32'(e));
      end
    end
  end

  initial begin
    rst  = 1'b1;
    tick = 1'b0;
    repeat (2) @(posedge clk);

    clr(); play(100);
    clr(); sched[10] = 1; sched[30] = 1; sched[50] = 1; play(80);
    clr(); sched[10] = 1; sched[12] = 1; sched[20] = 1; play(40);
    clr(); sched[10] = 1; sched[30] = 1; sched[100] = 1; sched[120] = 1; play(150);
    clr(); sched[10] = 1; sched[60] = 1; play(90);
    clr(); sched[10] = 1; sched[12] = 1; sched[13] = 1; play(30);
    clr(); for (int i = 0; i < 17; i++) sched[10 + 10 * i] = 1; play(190);
    clr(); sched[10] = 1; sched[30] = 1; rsched[40] = 1; sched[45] = 1; play(60);

    for (int s = 0; s < 20; s++) begin
      int gap;
      clr();
      gap = $urandom_range(1, 20);
      for (int i = 0; i < 256; i++) begin
        if (gap == 0) begin
          sched[i] = 1'b1;
          if ($urandom_range(0, 3) == 0) gap = $urandom_range(0, MIN_P);
          else gap = $urandom_range(MIN_P - 1, TMO + 10);
        end else begin
          gap--;
        end
        rsched[i] = ($urandom_range(0, 199) == 0);
      end
      play(256);
    end

    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wheel_period_meter.md
Name: wheel_period_meter

Overview:
Consumes the single-cycle rising-edge tick from the wheel-sensor edge detector. Once per revolution, it measures the number of clock cycles between consecutive accepted ticks. It rejects ticks that arrive too soon (reed bounce or double-trigger) and flags the wheel as stopped when no tick arrives within a timeout. Its outputs feed the speed/distance calculation and the display logic.

Parameters:
CNT_W, 32, width of the elapsed-cycle counter and of period; must satisfy TIMEOUT < 2^CNT_W.
MIN_PERIOD, 2_500_000, minimum accepted tick spacing in cycles (50 ms at 50 MHz).
TIMEOUT, 100_000_000, cycles without an accepted tick before stopped is declared (2 s at 50 MHz); must be > MIN_PERIOD.
REV_W, 16, width of the revolution counter.

Ports:
clk  input  1  system clock; all logic on its rising edge.
rst  input  1  synchronous, active-high reset.
tick  input  1  single-cycle pulse, one per wheel revolution edge.
period  output  CNT_W  last measured period in clk cycles; registered.
period_valid  output  1  one-cycle pulse when period is updated.
stopped  output  1  level; high while the wheel is considered stationary.
reject  output  1  one-cycle pulse when a tick is discarded as too early.
rev_count  output  REV_W  accepted-tick count; wraps modulo 2^REV_W.

Behaviour:
- Reset (rst high at a clk edge):
  - state = IDLE, elapsed = 0, period = 0, period_valid = 0, stopped = 1, reject = 0, rev_count = 0.
  - Reset asserted mid-measurement discards the measurement in progress; no valid pulse is produced.
- elapsed is the number of cycles since the last accepted tick. It reads 1 on the cycle after an accepted tick and increments by 1 per cycle. It never exceeds TIMEOUT, so it never wraps.
- State IDLE (no reference tick yet):
  - elapsed is held at 0.
  - tick = 1: accept the tick, rev_count += 1, go to MEASURE. No period_valid is produced because there is no previous reference. stopped stays 1.
- State MEASURE:
  - tick = 1 and elapsed < MIN_PERIOD: the tick is ignored. Next cycle reject = 1. elapsed continues counting; the reference point is not moved.
  - tick = 1 and elapsed >= MIN_PERIOD: accept the tick. Next cycle:
    - period = elapsed value at the tick cycle, i.e. t1 - t0 for accepted ticks at cycles t0 and t1;
    - period_valid = 1 and stopped = 0;
    - rev_count += 1;
    - elapsed restarts (reads 1).
    - Stay in MEASURE.
  - tick = 0 and elapsed == TIMEOUT: go to IDLE. Next cycle stopped = 1 and period = 0. No period_valid pulse is produced.
  - Simultaneous tick and elapsed == TIMEOUT: the tick wins and is accepted with period = TIMEOUT; no timeout occurs.
- Latency: all outputs are registered. period_valid and reject appear exactly 1 cycle after the tick cycle. Both are high for exactly one cycle and are never high together.
- stopped first deasserts on the second accepted tick, i.e. the first valid period. It reasserts only on timeout or reset.
- Back-to-back ticks on consecutive cycles in MEASURE: the second and later ticks are rejected individually, each with its own reject pulse.
- The default/illegal state recovers to IDLE on the next cycle with outputs at their reset values.

Test Plan:
All scenarios use CNT_W=16, MIN_PERIOD=5, TIMEOUT=50, REV_W=4.
- Reset, then idle for 100 cycles -> period=0, period_valid never high, stopped=1, rev_count=0.
- Ticks at cycles 10, 30, 50 -> period_valid pulses at 31 and 51 with period=20 both times. stopped falls at 31. rev_count=3.
- Ticks at 10, 12, 20 -> reject pulse at 13. period_valid at 21 with period=10 (reference stays at 10). rev_count=2.
- Ticks at 10 and 30, then silence -> timeout at elapsed 50 (cycle 80). stopped=1 and period=0 from cycle 81. A new tick at 100 produces no period_valid. A tick at 120 gives period=20.
- Ticks at 10 and 60 (elapsed == TIMEOUT) -> period=50 with valid at 61, stopped stays 0. Separately, ticks at 10, 12, 13 -> two reject pulses, at 13 and 14. Separately, 17 ticks spaced 10 apart -> rev_count wraps to 1.
- Ticks at 10 and 30, rst high at cycle 40, tick at 45 -> all outputs at reset values from 41, no period_valid at 46. rev_count=1 after the tick at 45.
